// File: rtl/alarm_pkg.sv
// Shared types and BCD helpers for the multi-alarm clock.
package alarm_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RINGING,
    SNOOZED
  } alarm_state_e;

  typedef struct packed {
    logic [1:0] h1;
    logic [3:0] h0;
    logic [3:0] m1;
    logic [3:0] m0;
  } bcd_hm_t;

  typedef struct packed {
    bcd_hm_t    hm;
    logic [3:0] s1;
    logic [3:0] s0;
  } bcd_time_t;

  function automatic logic bcd_time_valid(input bcd_hm_t t);
    logic hour_ok;
    hour_ok = (t.h1 < 2'd2) ? (t.h0 <= 4'd9) : ((t.h1 == 2'd2) && (t.h0 <= 4'd3));
    return hour_ok && (t.m1 <= 4'd5) && (t.m0 <= 4'd9);
  endfunction

  // Adds a constant number of minutes (< 60) to hh:mm, wrapping at 24 h.
  function automatic bcd_hm_t bcd_add_minutes(input bcd_hm_t t, input int unsigned mins);
    logic [6:0] m;
    logic [4:0] h;
    bcd_hm_t    r;
    m = 7'(t.m1) * 7'd10 + 7'(t.m0) + 7'(mins);
    h = 5'(t.h1) * 5'd10 + 5'(t.h0);
    if (m >= 7'd60) begin
      m = m - 7'd60;
      h = h + 5'd1;
    end
    if (h >= 5'd24) h = h - 5'd24;
    r = '0;
    for (int unsigned i = 0; i < 5; i++) begin
      if (m >= 7'd10) begin
        m    = m - 7'd10;
        r.m1 = r.m1 + 4'd1;
      end
    end
    r.m0 = m[3:0];
    for (int unsigned i = 0; i < 2; i++) begin
      if (h >= 5'd10) begin
        h    = h - 5'd10;
        r.h1 = r.h1 + 2'd1;
      end
    end
    r.h0 = h[3:0];
    return r;
  endfunction

endpackage

// File: rtl/bcd_time_counter.sv
// BCD hh:mm:ss counter: synchronous load has priority over the tick enable.
module bcd_time_counter
  import alarm_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      tick,
  input  logic      load,
  input  bcd_time_t load_val,
  output bcd_time_t cur_time
);

  bcd_time_t time_q, time_d;

  always_comb begin
    time_d = time_q;
    if (load) begin
      time_d = load_val;
    end else if (tick) begin
      if (time_q.s0 != 4'd9) begin
        time_d.s0 = time_q.s0 + 4'd1;
      end else begin
        time_d.s0 = 4'd0;
        if (time_q.s1 != 4'd5) begin
          time_d.s1 = time_q.s1 + 4'd1;
        end else begin
          time_d.s1 = 4'd0;
          if (time_q.hm.m0 != 4'd9) begin
            time_d.hm.m0 = time_q.hm.m0 + 4'd1;
          end else begin
            time_d.hm.m0 = 4'd0;
            if (time_q.hm.m1 != 4'd5) begin
              time_d.hm.m1 = time_q.hm.m1 + 4'd1;
            end else begin
              time_d.hm.m1 = 4'd0;
              if ((time_q.hm.h1 == 2'd2) && (time_q.hm.h0 == 4'd3)) begin
                time_d.hm.h1 = 2'd0;
                time_d.hm.h0 = 4'd0;
              end else if (time_q.hm.h0 == 4'd9) begin
                time_d.hm.h0 = 4'd0;
                time_d.hm.h1 = time_q.hm.h1 + 2'd1;
              end else begin
                time_d.hm.h0 = time_q.hm.h0 + 4'd1;
              end
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) time_q <= '0;
    else        time_q <= time_d;
  end

  assign cur_time = time_q;

endmodule

// File: rtl/multi_alarm_clock.sv
// 24-hour BCD clock with N alarm slots, snooze and ring timeout; single clock domain.
module multi_alarm_clock
  import alarm_pkg::*;
#(
  parameter int CLK_DIV        = 10,
  parameter int N_ALARMS       = 4,
  parameter int SNOOZE_MIN     = 5,
  parameter int RING_TIMEOUT_S = 60,
  localparam int AW = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [1:0]          H_in1,
  input  logic [3:0]          H_in0,
  input  logic [3:0]          M_in1,
  input  logic [3:0]          M_in0,
  input  logic                LD_time,
  input  logic                LD_alarm,
  input  logic [AW-1:0]       al_sel,
  input  logic [N_ALARMS-1:0] AL_ON,
  input  logic                STOP_al,
  input  logic                SNOOZE,
  output logic                Alarm,
  output logic [AW-1:0]       alarm_id,
  output logic                snoozed,
  output logic                load_err,
  output logic                tick_1s,
  output logic [1:0]          H_out1,
  output logic [3:0]          H_out0,
  output logic [3:0]          M_out1,
  output logic [3:0]          M_out0,
  output logic [3:0]          S_out1,
  output logic [3:0]          S_out0
);

  localparam int DW = $clog2(CLK_DIV);

  bcd_hm_t      in_hm;
  bcd_time_t    load_val, cur;
  logic         in_valid, sel_ok, time_ld, alarm_ld, load_err_d;
  logic         tick, sec_zero;
  logic [DW-1:0] div_q, div_d;
  logic         match_en_q, match_en_d, load_err_q;
  bcd_hm_t      al_q [N_ALARMS];
  bcd_hm_t      al_d [N_ALARMS];
  logic         hit, id_on;
  logic [AW-1:0] win;
  alarm_state_e state_q, state_d;
  logic [AW-1:0] alarm_id_q, alarm_id_d;
  logic [7:0]   ring_cnt_q, ring_cnt_d;
  bcd_hm_t      snooze_q, snooze_d;

  assign in_hm      = {H_in1, H_in0, M_in1, M_in0};
  assign load_val   = {in_hm, 8'h00};
  assign in_valid   = bcd_time_valid(in_hm);
  assign sel_ok     = 32'(al_sel) < 32'(N_ALARMS);
  assign time_ld    = LD_time & in_valid;
  assign alarm_ld   = LD_alarm & in_valid & sel_ok;
  assign load_err_d = (LD_time & ~in_valid) | (LD_alarm & ~(in_valid & sel_ok));
  assign sec_zero   = (cur.s1 == 4'd0) && (cur.s0 == 4'd0);

  // A tick swallowed by a same-cycle time load must not arm the match check.
  always_comb begin
    tick       = (div_q == DW'(CLK_DIV - 1));
    div_d      = tick ? '0 : div_q + DW'(1);
    if (time_ld) div_d = '0;
    match_en_d = tick & ~time_ld;
  end

  always_comb begin
    for (int unsigned k = 0; k < N_ALARMS; k++) begin
      al_d[k] = al_q[k];
      if (alarm_ld && (32'(al_sel) == k)) al_d[k] = in_hm;
    end
  end

  always_comb begin
    hit   = 1'b0;
    win   = '0;
    id_on = 1'b0;
    for (int unsigned k = 0; k < N_ALARMS; k++) begin
      if (!hit && AL_ON[k] && (al_q[k] == cur.hm) && sec_zero) begin
        hit = 1'b1;
        win = AW'(k);
      end
      if (32'(alarm_id_q) == k) id_on = AL_ON[k];
    end
  end

  bcd_time_counter u_time (
    .clk      (clk),
    .rst_n    (reset_n),
    .tick     (tick),
    .load     (time_ld),
    .load_val (load_val),
    .cur_time (cur)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q      <= '0;
      match_en_q <= 1'b0;
      load_err_q <= 1'b0;
      for (int unsigned k = 0; k < N_ALARMS; k++) al_q[k] <= '0;
    end else begin
      div_q      <= div_d;
      match_en_q <= match_en_d;
      load_err_q <= load_err_d;
      al_q       <= al_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      alarm_id_q <= '0;
      ring_cnt_q <= '0;
      snooze_q   <= '0;
    end else begin
      state_q    <= state_d;
      alarm_id_q <= alarm_id_d;
      ring_cnt_q <= ring_cnt_d;
      snooze_q   <= snooze_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    alarm_id_d = alarm_id_q;
    ring_cnt_d = ring_cnt_q;
    snooze_d   = snooze_q;
    unique case (state_q)
      IDLE: begin
        if (match_en_q && hit) begin
          state_d    = RINGING;
          alarm_id_d = win;
          ring_cnt_d = '0;
        end
      end
      RINGING: begin
        if (STOP_al || !id_on) begin
          state_d = IDLE;
        end else if (SNOOZE) begin
          state_d  = SNOOZED;
          snooze_d = bcd_add_minutes(cur.hm, SNOOZE_MIN);
        end else if (tick) begin
          ring_cnt_d = ring_cnt_q + 8'd1;
          if (ring_cnt_d == 8'(RING_TIMEOUT_S)) state_d = IDLE;
        end
      end
      SNOOZED: begin
        if (STOP_al || !id_on) begin
          state_d = IDLE;
        end else if (match_en_q && sec_zero && (cur.hm == snooze_q)) begin
          state_d    = RINGING;
          ring_cnt_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    Alarm   = (state_q == RINGING);
    snoozed = (state_q == SNOOZED);
  end

  assign alarm_id = alarm_id_q;
  assign load_err = load_err_q;
  assign tick_1s  = tick;
  assign H_out1   = cur.hm.h1;
  assign H_out0   = cur.hm.h0;
  assign M_out1   = cur.hm.m1;
  assign M_out0   = cur.hm.m0;
  assign S_out1   = cur.s1;
  assign S_out0   = cur.s0;

endmodule

// File: tb/tb_multi_alarm_clock.sv
// Directed bench for multi_alarm_clock: time keeping, alarms, snooze, timeout, load checks.
module tb_multi_alarm_clock;

  localparam int CLK_DIV = 10;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [1:0] H_in1;
  logic [3:0] H_in0, M_in1, M_in0;
  logic       LD_time, LD_alarm, STOP_al, SNOOZE;
  logic [1:0] al_sel;
  logic [3:0] AL_ON;
  logic       Alarm, snoozed, load_err, tick_1s;
  logic [1:0] alarm_id;
  logic [1:0] H_out1;
  logic [3:0] H_out0, M_out1, M_out0, S_out1, S_out0;

  int checks = 0;
  int passed = 0;

  multi_alarm_clock #(
    .CLK_DIV        (CLK_DIV),
    .N_ALARMS       (4),
    .SNOOZE_MIN     (5),
    .RING_TIMEOUT_S (60)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .H_in1    (H_in1),
    .H_in0    (H_in0),
    .M_in1    (M_in1),
    .M_in0    (M_in0),
    .LD_time  (LD_time),
    .LD_alarm (LD_alarm),
    .al_sel   (al_sel),
    .AL_ON    (AL_ON),
    .STOP_al  (STOP_al),
    .SNOOZE   (SNOOZE),
    .Alarm    (Alarm),
    .alarm_id (alarm_id),
    .snoozed  (snoozed),
    .load_err (load_err),
    .tick_1s  (tick_1s),
    .H_out1   (H_out1),
    .H_out0   (H_out0),
    .M_out1   (M_out1),
    .M_out0   (M_out0),
    .S_out1   (S_out1),
    .S_out0   (S_out0)
  );

  always #5 clk = ~clk;

  function automatic logic [21:0] now_t();
    return {H_out1, H_out0, M_out1, M_out0, S_out1, S_out0};
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_hm(input logic [1:0] h1, input logic [3:0] h0, input logic [3:0] m1,
                        input logic [3:0] m0);
    H_in1 = h1; H_in0 = h0; M_in1 = m1; M_in0 = m0;
  endtask

  task automatic do_load_time(input logic [1:0] h1, input logic [3:0] h0, input logic [3:0] m1,
                              input logic [3:0] m0);
    set_hm(h1, h0, m1, m0);
    LD_time = 1'b1;
    step(1);
    LD_time = 1'b0;
  endtask

  task automatic do_load_alarm(input logic [1:0] sel, input logic [1:0] h1, input logic [3:0] h0,
                               input logic [3:0] m1, input logic [3:0] m0);
    set_hm(h1, h0, m1, m0);
    al_sel   = sel;
    LD_alarm = 1'b1;
    step(1);
    LD_alarm = 1'b0;
  endtask

  // Returns at the first negedge after the n-th tick's time update.
  task automatic wait_ticks(input int n);
    int seen;
    int cyc;
    seen = 0;
    cyc  = 0;
    while (seen < n && cyc < (n + 2) * CLK_DIV) begin
      step(1);
      cyc++;
      if (tick_1s) seen++;
    end
    checks++;
    if (seen !== n) $display("FAIL tick_wait: got %0d ticks, expected %0d", seen, n);
    else passed++;
    step(1);
  endtask

  task automatic test_reset();
    int n;
    reset_n = 1'b0;
    set_hm(0, 0, 0, 0);
    LD_time = 0; LD_alarm = 0; al_sel = 0; AL_ON = 0; STOP_al = 0; SNOOZE = 0;
    step(2);
    checks++; if (Alarm !== 1'b0) $display("FAIL reset_alarm: got %b expected 0", Alarm); else passed++;
    checks++; if (alarm_id !== 2'd0) $display("FAIL reset_id: got %0d expected 0", alarm_id); else passed++;
    checks++; if (snoozed !== 1'b0) $display("FAIL reset_snoozed: got %b expected 0", snoozed); else passed++;
    checks++; if (load_err !== 1'b0) $display("FAIL reset_load_err: got %b expected 0", load_err); else passed++;
    checks++; if (tick_1s !== 1'b0) $display("FAIL reset_tick: got %b expected 0", tick_1s); else passed++;
    checks++; if (now_t() !== 22'h0) $display("FAIL reset_time: got %h expected 000000", now_t()); else passed++;
    reset_n = 1'b1;
    n = 0;
    while (!tick_1s && n < 50) begin step(1); n++; end
    checks++; if (n !== CLK_DIV - 1) $display("FAIL first_tick: got %0d cycles expected %0d", n, CLK_DIV - 1); else passed++;
    n = 0;
    do begin step(1); n++; end while (!tick_1s && n < 50);
    checks++; if (n !== CLK_DIV) $display("FAIL tick_period: got %0d expected %0d", n, CLK_DIV); else passed++;
  endtask

  task automatic test_rollover();
    do_load_time(2, 3, 5, 9);
    checks++; if (now_t() !== {2'd2, 20'h35900}) $display("FAIL load_2359: got %h expected %h", now_t(), {2'd2, 20'h35900}); else passed++;
    checks++; if (load_err !== 1'b0) $display("FAIL valid_no_err: got %b expected 0", load_err); else passed++;
    wait_ticks(59);
    checks++; if (now_t() !== {2'd2, 20'h35959}) $display("FAIL time_235959: got %h expected %h", now_t(), {2'd2, 20'h35959}); else passed++;
    wait_ticks(1);
    checks++; if (now_t() !== 22'h0) $display("FAIL wrap_000000: got %h expected 000000", now_t()); else passed++;
  endtask

  task automatic test_priority_match();
    AL_ON = 4'b0000;
    do_load_alarm(1, 0, 7, 3, 0);
    do_load_alarm(2, 0, 7, 3, 0);
    AL_ON = 4'b0110;
    do_load_time(0, 7, 2, 9);
    wait_ticks(58);
    checks++; if (now_t() !== {2'd0, 20'h72958}) $display("FAIL time_072958: got %h expected %h", now_t(), {2'd0, 20'h72958}); else passed++;
    checks++; if (Alarm !== 1'b0) $display("FAIL early_alarm: got %b expected 0", Alarm); else passed++;
    wait_ticks(2);
    checks++; if (now_t() !== {2'd0, 20'h73000}) $display("FAIL time_073000: got %h expected %h", now_t(), {2'd0, 20'h73000}); else passed++;
    step(1);
    checks++; if (Alarm !== 1'b1) $display("FAIL match_ring: got %b expected 1", Alarm); else passed++;
    checks++; if (alarm_id !== 2'd1) $display("FAIL lowest_id: got %0d expected 1", alarm_id); else passed++;
    STOP_al = 1'b1;
    step(1);
    STOP_al = 1'b0;
    checks++; if (Alarm !== 1'b0) $display("FAIL stop: got %b expected 0", Alarm); else passed++;
    checks++; if (snoozed !== 1'b0) $display("FAIL stop_snoozed: got %b expected 0", snoozed); else passed++;
  endtask

  task automatic test_snooze();
    AL_ON = 4'b0000;
    do_load_alarm(0, 2, 3, 5, 8);
    AL_ON = 4'b0001;
    do_load_time(2, 3, 5, 7);
    wait_ticks(60);
    step(1);
    checks++; if (Alarm !== 1'b1) $display("FAIL ring_2358: got %b expected 1", Alarm); else passed++;
    checks++; if (alarm_id !== 2'd0) $display("FAIL ring_2358_id: got %0d expected 0", alarm_id); else passed++;
    SNOOZE = 1'b1;
    step(1);
    SNOOZE = 1'b0;
    checks++; if (Alarm !== 1'b0) $display("FAIL snooze_alarm: got %b expected 0", Alarm); else passed++;
    checks++; if (snoozed !== 1'b1) $display("FAIL snooze_flag: got %b expected 1", snoozed); else passed++;
    wait_ticks(299);
    checks++; if ((now_t() !== {2'd0, 20'h00259}) || Alarm !== 1'b0) $display("FAIL snooze_early: got time %h alarm %b expected 000259 0", now_t(), Alarm); else passed++;
    wait_ticks(1);
    checks++; if (now_t() !== {2'd0, 20'h00300}) $display("FAIL time_000300: got %h expected %h", now_t(), {2'd0, 20'h00300}); else passed++;
    step(1);
    checks++; if (Alarm !== 1'b1) $display("FAIL snooze_ring: got %b expected 1", Alarm); else passed++;
    checks++; if (alarm_id !== 2'd0) $display("FAIL snooze_id: got %0d expected 0", alarm_id); else passed++;
    checks++; if (snoozed !== 1'b0) $display("FAIL snooze_cleared: got %b expected 0", snoozed); else passed++;
    AL_ON = 4'b0000;
    step(1);
    checks++; if (Alarm !== 1'b0) $display("FAIL al_on_drop: got %b expected 0", Alarm); else passed++;
  endtask

  task automatic test_timeout();
    int cnt;
    int cyc;
    AL_ON = 4'b0001;
    do_load_time(2, 3, 5, 7);
    wait_ticks(60);
    step(1);
    checks++; if (Alarm !== 1'b1) $display("FAIL timeout_start: got %b expected 1", Alarm); else passed++;
    cnt = 0;
    cyc = 0;
    while (Alarm && cyc < 800) begin
      if (tick_1s) cnt++;
      step(1);
      cyc++;
    end
    checks++; if (cnt !== 60) $display("FAIL timeout_ticks: got %0d expected 60", cnt); else passed++;
    checks++; if ((Alarm !== 1'b0) || (snoozed !== 1'b0)) $display("FAIL timeout_idle: got alarm %b snoozed %b expected 0 0", Alarm, snoozed); else passed++;
    AL_ON = 4'b0000;
  endtask

  task automatic test_load_err();
    AL_ON = 4'b0000;
    do_load_alarm(3, 1, 2, 0, 0);
    checks++; if (load_err !== 1'b0) $display("FAIL alarm_valid_err: got %b expected 0", load_err); else passed++;
    set_hm(2, 5, 0, 0);
    al_sel = 3;
    LD_alarm = 1'b1;
    step(1);
    LD_alarm = 1'b0;
    checks++; if (load_err !== 1'b1) $display("FAIL alarm_25_err: got %b expected 1", load_err); else passed++;
    step(1);
    checks++; if (load_err !== 1'b0) $display("FAIL err_one_cycle: got %b expected 0", load_err); else passed++;
    do_load_time(1, 1, 5, 9);
    set_hm(1, 2, 6, 0);
    LD_time = 1'b1;
    step(1);
    LD_time = 1'b0;
    checks++; if (load_err !== 1'b1) $display("FAIL time_m6_err: got %b expected 1", load_err); else passed++;
    checks++; if (now_t() !== {2'd1, 20'h15900}) $display("FAIL time_kept: got %h expected %h", now_t(), {2'd1, 20'h15900}); else passed++;
    set_hm(2, 4, 0, 0);
    LD_time = 1'b1;
    step(1);
    LD_time = 1'b0;
    checks++; if ((load_err !== 1'b1) || (now_t() !== {2'd1, 20'h15900})) $display("FAIL time_24_err: got err %b time %h expected 1 115900", load_err, now_t()); else passed++;
    AL_ON = 4'b1000;
    wait_ticks(60);
    step(1);
    checks++; if ((Alarm !== 1'b1) || (alarm_id !== 2'd3)) $display("FAIL slot_kept: got alarm %b id %0d expected 1 3", Alarm, alarm_id); else passed++;
  endtask

  task automatic test_reset_mid_ring();
    logic bad;
    reset_n = 1'b0;
    #1;
    checks++; if (Alarm !== 1'b0) $display("FAIL async_reset_alarm: got %b expected 0", Alarm); else passed++;
    checks++; if (now_t() !== 22'h0) $display("FAIL async_reset_time: got %h expected 000000", now_t()); else passed++;
    step(1);
    reset_n = 1'b1;
    bad = 1'b0;
    repeat (3 * CLK_DIV + 2) begin
      step(1);
      if (Alarm) bad = 1'b1;
    end
    checks++; if (bad !== 1'b0) $display("FAIL no_resume: got alarm seen %b expected 0", bad); else passed++;
    checks++; if (now_t() !== {2'd0, 20'h00003}) $display("FAIL post_reset_time: got %h expected 000003", now_t()); else passed++;
  endtask

  initial begin
    test_reset();
    test_rollover();
    test_priority_match();
    test_snooze();
    test_timeout();
    test_load_err();
    test_reset_mid_ring();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
